serial_mod5_tx: RTL
===================

// Module: serial_mod5_tx
// PURPOSE
//  Parallel-in, serial-out transmitter that drives MSB-first bit streams into the mod-5 serial checker.
//  Accepts a WIDTH-bit word over a valid/ready handshake and emits one bit per clk.
//  Tracks the running residue mod 5 of the bits sent, so the bench can compare it against the checker's verdict.
//  Optionally appends 3 pad bits so that every frame is divisible by 5.
// PARAMETERS
//  WIDTH   8   data word width in bits; legal range 2..32
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  din         in   WIDTH  parallel word to transmit; bit WIDTH-1 is sent first
//  din_valid   in   1      din is valid
//  din_ready   out  1      block can accept a word
//  sout        out  1      serial data bit
//  sout_valid  out  1      sout carries a frame bit this cycle
//  sout_last   out  1      current bit is the final bit of the frame
//  residue     out  3      (value of bits emitted so far in frame) mod 5; range 0..4
//  busy        out  1      a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset values: state IDLE; din_ready=1; sout=0; sout_valid=0; sout_last=0; residue=0; busy=0.
//  All outputs are registered.
//  FSM states:
//   - IDLE: din_ready=1. On din_valid&&din_ready, capture din into shift reg,
//     clear residue to 0, bit count = 0, go to SHIFT.
//   - SHIFT: sout=shreg[WIDTH-1], sout_valid=1, shift left by 1 each clk.
//     sout_last=1 on bit WIDTH-1 when PAD is off.
//     After WIDTH bits: go to PAD if enabled, else IDLE.
//   - PAD (MOD5_PAD_EN only): emit 3 bits, MSB first; sout_valid=1;
//     sout_last=1 on the 3rd bit; then go to IDLE.
//  Latency: the first bit appears on sout in the cycle after the handshake clk edge.
//   Frame length is WIDTH bits (WIDTH+3 with PAD).
//   There is one IDLE bubble cycle between frames; din_ready=0 in SHIFT and PAD.
//  Residue update: on every clk edge where sout_valid=1,
//   residue <= (2*residue + sout) mod 5.
//   Use a 5-entry case table; no multiplier or divider.
//  residue holds its final frame value through IDLE until the next handshake clears it.
//  din and din_valid are ignored outside IDLE. din is sampled only at the handshake edge.
//  din_valid=1 in IDLE with back-to-back words: one word is accepted per frame, with one bubble cycle.
//  Reset mid-frame: the frame is abandoned immediately and all outputs return to reset values.
//   No partial-frame resume.
//  Illegal state encoding: recover to IDLE with reset output values.
// CONFIGURATION
//  MOD5_PAD_EN defined:
//   - At end of data, pad p = (2*r) mod 5, where r is the residue after the data bits.
//     p is in 0..4 and is sent as 3 bits.
//   - Total value = 8*data + p, which is always 0 mod 5, so residue=0 at frame end.
//  MOD5_PAD_EN undefined:
//   - PAD state is absent.
//   - Frame is data only; the final residue equals din mod 5.
// TESTING
//  T1 reset: assert reset mid-SHIFT -> next cycle sout_valid=0, din_ready=1, residue=0, busy=0.
//  T2 WIDTH=8, din=8'h0A -> sout 0,0,0,0,1,0,1,0 over 8 cycles;
//     sout_last on 8th bit; final residue=0.
//  T3 din=8'h07, no PAD -> residue sequence 0,0,0,0,0,1,3,2; final residue=2.
//  T4 MOD5_PAD_EN, din=8'h0D (13, r=3) -> pad bits 0,0,1; value 105; final residue=0.
//     Same for din=8'h07 -> pad 1,0,0 (value 60), final residue=0.
//  T5 din_valid held high with words 8'hFF then 8'h01:
//     - din_ready low during SHIFT; exactly one IDLE bubble between frames.
//     - Final residues 0 and 1 (no PAD).
//  T6 loopback into the mod-5 checker, all 256 words:
//     checker output after the last bit == (residue==0) in every case.

Source files
------------

// File: rtl/serial_mod5_tx.sv
// MSB-first parallel-to-serial transmitter that tracks the running residue mod 5 of the bits sent.
// Define MOD5_PAD_EN to append 3 pad bits so that every frame value is divisible by 5.
module serial_mod5_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic [2:0]       residue,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef MOD5_PAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [2:0]       res_nxt;
`ifdef MOD5_PAD_EN
    logic [1:0]       pad_sh;
    logic [2:0]       pad_val;
`endif

    // (2*r + b) mod 5 as a lookup
    function automatic logic [2:0] res_step(input logic [2:0] r, input logic b);
        case (r)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd3 : 3'd2;
            3'd2:    return b ? 3'd0 : 3'd4;
            3'd3:    return b ? 3'd2 : 3'd1;
            3'd4:    return b ? 3'd4 : 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    assign res_nxt = res_step(residue, sout);

`ifdef MOD5_PAD_EN
    // Pad (2*r) mod 5 clears the residue after three more doublings
    always_comb begin
        pad_val = 3'd0;
        case (res_nxt)
            3'd1:    pad_val = 3'd2;
            3'd2:    pad_val = 3'd4;
            3'd3:    pad_val = 3'd1;
            3'd4:    pad_val = 3'd3;
            default: pad_val = 3'd0;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            din_ready  <= 1'b1;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            residue    <= 3'd0;
            busy       <= 1'b0;
`ifdef MOD5_PAD_EN
            pad_sh     <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid && din_ready) begin
                        shreg      <= din << 1;
                        sout       <= din[WIDTH-1];
                        sout_valid <= 1'b1;
                        sout_last  <= 1'b0;
                        residue    <= 3'd0;
                        cnt        <= CW'(1);
                        din_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    residue <= res_nxt;
                    if (cnt == CW'(WIDTH)) begin
`ifdef MOD5_PAD_EN
                        sout      <= pad_val[2];
                        pad_sh    <= pad_val[1:0];
                        sout_last <= 1'b0;
                        cnt       <= CW'(1);
                        state     <= PAD;
`else
                        state      <= IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                        din_ready  <= 1'b1;
                        busy       <= 1'b0;
`endif
                    end else begin
                        sout  <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt + CW'(1);
`ifdef MOD5_PAD_EN
                        sout_last <= 1'b0;
`else
                        sout_last <= (cnt == CW'(WIDTH - 1));
`endif
                    end
                end
`ifdef MOD5_PAD_EN
                PAD: begin
                    residue <= res_nxt;
                    if (cnt == CW'(3)) begin
                        state      <= IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                        din_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        sout      <= pad_sh[1];
                        pad_sh    <= {pad_sh[0], 1'b0};
                        cnt       <= cnt + CW'(1);
                        sout_last <= (cnt == CW'(2));
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    shreg      <= '0;
                    cnt        <= '0;
                    din_ready  <= 1'b1;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    sout_last  <= 1'b0;
                    residue    <= 3'd0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule
